// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: runs one valid/ready bus transfer per access
// and returns an aligned, extended load result to writeback.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] mem_read_data,
  output logic        misalign,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       mem_read_data_q, mem_read_data_d;
  logic              misalign_q, misalign_d;
  logic              bus_error_q, bus_error_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic        is_op, aligned, access_ok;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, lane_c, load_c;

  // Decode the incoming access: legality, byte enables, lane-replicated data
  always_comb begin
    is_op = memread | memwrite;
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    access_ok = (memread ^ memwrite) & aligned;
    case (size)
      2'b00:   be_c = 4'b0001 << addr[1:0];
      2'b01:   be_c = 4'b0011 << addr[1:0];
      default: be_c = 4'b1111;
    endcase
    case (size)
      2'b00:   wdata_c = {4{store_data[7:0]}};
      2'b01:   wdata_c = {2{store_data[15:0]}};
      default: wdata_c = store_data;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    lane_c = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_c = uns_q ? {24'h0, lane_c[7:0]}  : {{24{lane_c[7]}},  lane_c[7:0]};
      2'b01:   load_c = uns_q ? {16'h0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
      default: load_c = lane_c;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    off_d           = off_q;
    size_d          = size_q;
    uns_d           = uns_q;
    mem_read_data_d = mem_read_data_q;
    misalign_d      = 1'b0;
    bus_error_d     = 1'b0;
    bus_req_d       = bus_req_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_be_d        = bus_be_q;
    bus_wdata_d     = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (access_ok) begin
          state_d     = REQ;
          cnt_d       = '0;
          off_d       = addr[1:0];
          size_d      = size;
          uns_d       = load_unsigned;
          bus_req_d   = 1'b1;
          bus_we_d    = memwrite;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = be_c;
          bus_wdata_d = wdata_c;
        end else if (is_op) begin
          misalign_d = 1'b1;
        end
      end
      REQ: begin
        // A ready in the final timeout cycle still completes the transfer
        if (bus_ready) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_read_data_d = load_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = DONE;
          bus_req_d       = 1'b0;
          bus_error_d     = 1'b1;
          mem_read_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      off_q           <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      mem_read_data_q <= '0;
      misalign_q      <= 1'b0;
      bus_error_q     <= 1'b0;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_be_q        <= '0;
      bus_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      off_q           <= off_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      mem_read_data_q <= mem_read_data_d;
      misalign_q      <= misalign_d;
      bus_error_q     <= bus_error_d;
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_be_q        <= bus_be_d;
      bus_wdata_q     <= bus_wdata_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the detect cycle itself
  assign stall         = ((state_q == IDLE) && access_ok) || (state_q == REQ);
  assign mem_read_data = mem_read_data_q;
  assign misalign      = misalign_q;
  assign bus_error     = bus_error_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
